// File: rtl/tpu_a_skew_feeder.sv
// Row-buffered skew feeder for the west edge of the systolic MAC array.
// Stores a DIM x DIM signed A-matrix, then streams it with row i delayed i beats.
module tpu_a_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int CNT_W   = $clog2(2*DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic [$clog2(DIM)-1:0]    Arow,
  input  logic signed [BITS_AB-1:0] Ain  [DIM],
  input  logic                      start,
  output logic signed [BITS_AB-1:0] Aout [DIM],
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [BITS_AB-1:0] abuf_q [DIM][DIM];
  logic signed [BITS_AB-1:0] abuf_d [DIM][DIM];
  logic signed [BITS_AB-1:0] aout_q [DIM];
  logic signed [BITS_AB-1:0] aout_d [DIM];
  logic signed [BITS_AB-1:0] beat   [DIM];
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      last_beat;

  // Row i carries column j on beat i+j; every other slot is zero padding.
  always_comb begin
    beat = '{default: '0};
    for (int unsigned i = 0; i < DIM; i++) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        if (32'(cnt_q) == i + j) beat[i] = abuf_q[i][j];
      end
    end
  end

  assign last_beat = (32'(cnt_q) == 32'(2*DIM - 2));

  always_comb begin
    abuf_d = abuf_q;
    if (state_q == IDLE && WrEn && 32'(Arow) < 32'(DIM)) begin
      abuf_d[Arow] = Ain;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aout_d  = aout_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        aout_d  = '{default: '0};
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (en) begin
          aout_d  = beat;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          done_d  = last_beat;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abuf_q  <= '{default: '{default: '0}};
      aout_q  <= '{default: '0};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abuf_q  <= abuf_d;
      aout_q  <= aout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Aout  = aout_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = (state_q == STREAM);

endmodule

// File: tb/tb_tpu_a_skew_feeder.sv
// Directed bench for tpu_a_skew_feeder at DIM=4 with hand-computed beat tables.
module tb_tpu_a_skew_feeder;

  logic              clk = 1'b0;
  logic              rst_n, en, WrEn, start;
  logic [1:0]        Arow;
  logic signed [7:0] Ain  [4];
  logic signed [7:0] Aout [4];
  logic              valid, busy, done;
  logic [31:0]       pk;
  logic [31:0]       exp_t [7];
  int                nvec = 0;
  int                nerr = 0;

  tpu_a_skew_feeder #(.BITS_AB(8), .DIM(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
    .start(start), .Aout(Aout), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Aout[0] in the low byte
  assign pk = {Aout[3], Aout[2], Aout[1], Aout[0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a, input logic v,
                         input logic d, input logic b);
    chk({tag, "_aout"},  pk, a);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, "_done"},  {31'b0, done},  {31'b0, d});
    chk({tag, "_busy"},  {31'b0, busy},  {31'b0, b});
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] row);
    WrEn = 1'b1;
    Arow = r;
    for (int c = 0; c < 4; c++) Ain[c] = row[8*c +: 8];
    step();
    WrEn = 1'b0;
  endtask

  task automatic stream_check(input string nm);
    for (int k = 0; k < 7; k++) begin
      step();
      chk_out($sformatf("%s_b%0d", nm, k), exp_t[k], 1'b1, k == 6, k != 6);
    end
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("kick", 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; WrEn = 1'b0; start = 1'b0; Arow = '0;
    Ain = '{default: '0};
    #3;
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    #4 rst_n = 1'b1;

    // A[r][c] = 4r+c+1
    wr(2'd0, 32'h04030201);
    wr(2'd1, 32'h08070605);
    wr(2'd2, 32'h0C0B0A09);
    wr(2'd3, 32'h100F0E0D);
    exp_t = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
              32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
    en = 1'b1;
    kick();
    stream_check("base");
    step();
    chk_out("base_after", 32'h0, 1'b0, 1'b0, 1'b0);

    // two stall cycles after beat 2
    kick();
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stall_b%0d", k), exp_t[k], 1'b1, 1'b0, 1'b1);
    end
    en = 1'b0;
    step();
    chk_out("stall_h0", exp_t[2], 1'b1, 1'b0, 1'b1);
    step();
    chk_out("stall_h1", exp_t[2], 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    for (int k = 3; k < 7; k++) begin
      step();
      chk_out($sformatf("stall_b%0d", k), exp_t[k], 1'b1, k == 6, k != 6);
    end
    step();
    chk_out("stall_after", 32'h0, 1'b0, 1'b0, 1'b0);

    // write to row 1 during STREAM must be ignored
    kick();
    WrEn = 1'b1; Arow = 2'd1;
    Ain = '{-8'sd1, -8'sd2, -8'sd3, -8'sd4};
    for (int k = 0; k < 7; k++) begin
      step();
      chk_out($sformatf("wrs_b%0d", k), exp_t[k], 1'b1, k == 6, k != 6);
      if (k == 2) WrEn = 1'b0;
    end
    // restart in the done cycle; a mid-stream start is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("restart_gap", 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk_out($sformatf("restart_b%0d", k), exp_t[k], 1'b1, k == 6, k != 6);
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
    end
    step();
    chk_out("restart_after", 32'h0, 1'b0, 1'b0, 1'b0);

    // extreme signed values in row 2
    wr(2'd2, 32'h7F807F80);
    exp_t = '{32'h00000001, 32'h00000502, 32'h00800603, 32'h0D7F0704,
              32'h0E800800, 32'h0F7F0000, 32'h10000000};
    kick();
    stream_check("neg");
    step();

    // write row 0 and start on the same edge
    WrEn = 1'b1; Arow = 2'd0; Ain = '{8'sd9, 8'sd9, 8'sd9, 8'sd9};
    start = 1'b1;
    step();
    WrEn = 1'b0; start = 1'b0;
    step();
    chk_out("same_b0", 32'h00000009, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("same_b1", 32'h00000509, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("same_b2", 32'h00800609, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("same_b3", 32'h0D7F0709, 1'b1, 1'b0, 1'b1);

    // asynchronous reset mid-stream
    #1 rst_n = 1'b0;
    #1 chk_out("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_out($sformatf("rst_idle%0d", k), 32'h0, 1'b0, 1'b0, 1'b0);
    end

    // cleared buffer streams zeros
    exp_t = '{default: 32'h0};
    kick();
    stream_check("zero");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tpu_a_skew_feeder.md
# tpu_a_skew_feeder

Row-buffered skew feeder that sits directly upstream of the systolic MAC array and drives the west-edge A inputs of its rows. It stores a DIM×DIM signed A-matrix written one row per cycle, then on `start` streams it out diagonally skewed: row i is delayed i cycles so each row's operands meet the matching B operands in the array. Zeros pad the skew so the array accumulates nothing outside the valid diagonal. The `en` stall input is shared with the MAC array.

## Interface
- `BITS_AB`, 8, width of each signed A element; matches the MAC A/B width.
- `DIM`, 8, array dimension: rows, columns and buffer depth. Legal range 2..16.
- `CNT_W`, $clog2(2*DIM), beat counter width. Derived; never overridden.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `en`  in  1  global advance/stall, shared with the MAC array.
- `WrEn`  in  1  row write strobe.
- `Arow`  in  $clog2(DIM)  row index for the write.
- `Ain`  in  DIM×BITS_AB (signed, unpacked [DIM])  row data; `Ain[c]` is A[Arow][c].
- `start`  in  1  begin streaming the stored matrix.
- `Aout`  out  DIM×BITS_AB (signed, unpacked [DIM])  skewed A column; `Aout[i]` feeds array row i.
- `valid`  out  1  `Aout` holds a stream beat.
- `busy`  out  1  FSM in STREAM.
- `done`  out  1  one-beat flag marking the last beat.

## Operation
- Storage: `buf[r][c]`, DIM×DIM×BITS_AB, asynchronously cleared to 0. Contents persist across streams, so the matrix can be re-streamed without rewriting.
- Write: `WrEn` in IDLE sets `buf[Arow][c] <= Ain[c]` for all c on that edge.
  - Write in STREAM is ignored.
  - `Arow >= DIM` (non-power-of-2 DIM) is ignored.
  - A write does not depend on `en`.
- FSM has two states, IDLE and STREAM. Counter `cnt` is CNT_W bits.
  - IDLE, `start`=1: next state STREAM, `cnt <= 0`, `Aout <= 0`, `valid <= 0`. `start` does not depend on `en`.
  - STREAM, `en`=1: for every i, `Aout[i] <= buf[i][cnt-i]` if 0 <= cnt-i < DIM, else 0. `valid <= 1`, `cnt <= cnt+1`.
  - STREAM, `en`=1, `cnt == 2*DIM-2`: the last beat is registered as above, `done <= 1`, next state IDLE.
  - STREAM, `en`=0: `cnt`, `Aout`, `valid`, `done` and the state all hold.
  - IDLE without `start`: `Aout <= 0`, `valid <= 0`, `done <= 0`.
  - `start` in STREAM is ignored.
- Same edge in IDLE with both `WrEn` and `start`: the write occurs and the stream starts. The first beat is read after the edge, so it sees the new row.
- Arithmetic: no arithmetic on data. cnt-i is evaluated signed, or as the range check cnt >= i && cnt < i+DIM.
- `busy` is combinational from the state register: `busy = (state == STREAM)`.

## Timing
- Reset values: `Aout` all 0, `valid` 0, `done` 0, `busy` 0, state IDLE, `cnt` 0, `buf` all 0.
- Reset asserted mid-stream aborts immediately to these values. No `done` pulse is produced.
- `start` sampled at edge E0. `busy` is high from E0 until the edge that registers the last beat.
- With `en` held high, edge E0+k+1 registers beat k, for k = 0..2*DIM-2. That is 2*DIM-1 beats; the first beat appears one cycle after `start`.
- Element A[i][j] appears on `Aout[i]` at beat i+j.
- `done` and the last beat (`Aout[DIM-1]` = A[DIM-1][DIM-1], all other rows 0) are visible in the same cycle. The following edge clears `Aout`, `valid` and `done` unless a new `start` is taken.
- A new `start` is accepted in the `done` cycle. The stream restarts with one zero/invalid cycle before beat 0.
- Each `en`=0 cycle in STREAM adds exactly one cycle of latency. Outputs stay frozen for that cycle.

## Test plan
- DIM=4, write rows r with A[r][c] = 4r+c+1, `start`, `en`=1 → beats 0..6.
  - Beat 0: `Aout` = {1,0,0,0}.
  - Beat 3: `Aout` = {4,7,10,13}.
  - Beat 6: `Aout` = {0,0,0,16}, with `done`=1.
  - `valid` high for exactly 7 cycles.
- Same matrix, `en` low for 2 cycles after beat 2 → beat 2 is held 3 cycles, `cnt` frozen, `done` arrives 2 cycles later.
- `WrEn` of row 1 = {-1,-2,-3,-4} during STREAM → current stream unchanged; a re-stream still shows the old row 1. Negative values -128/127 in IDLE writes stream through unchanged.
- `WrEn` row 0 = {9,9,9,9} and `start` on the same edge → beat 0 `Aout[0]` = 9.
- `rst_n` pulsed low at beat 3 → all outputs 0 asynchronously, no `done`; a subsequent `start` streams all zeros.
- `start` in the `done` cycle → one zero cycle with `valid`=0, then beat 0 again. A second `start` during STREAM is ignored.
